// File: rtl/hdmi_period_sequencer_if.sv
// Video-in / encoder-control-out bundle of the HDMI period sequencer.
// The timing source is the master; the sequencer is the slave.
interface hdmi_period_sequencer_if;
   logic       active_in;
   logic       hsync_in;
   logic       vsync_in;
   logic [7:0] red_in;
   logic [7:0] green_in;
   logic [7:0] blue_in;
   logic       hdmi_mode_in;

   logic [7:0] red_out;
   logic [7:0] green_out;
   logic [7:0] blue_out;
   logic [1:0] c0_out;
   logic [1:0] c1_out;
   logic [1:0] c2_out;
   logic [1:0] mode_out;
   logic       violation_out;

   modport master (
      output active_in, hsync_in, vsync_in, red_in, green_in, blue_in, hdmi_mode_in,
      input  red_out, green_out, blue_out, c0_out, c1_out, c2_out, mode_out, violation_out
   );

   modport slave (
      input  active_in, hsync_in, vsync_in, red_in, green_in, blue_in, hdmi_mode_in,
      output red_out, green_out, blue_out, c0_out, c1_out, c2_out, mode_out, violation_out
   );
endinterface

// File: rtl/hdmi_period_sequencer.sv
// Delays pixel/sync/active by 10 pixel clocks and, in HDMI mode, replaces the
// last 10 control cycles before each long-gap active run with preamble + guard band.
module hdmi_period_sequencer (
   input  logic                   clk_pixel_in,
   input  logic                   rst_n_in,
   hdmi_period_sequencer_if.slave bus
);
   localparam int unsigned DELAY   = 10;
   localparam logic [3:0]  RUN_MIN = 4'd12;
   localparam logic [3:0]  PRE_LEN = 4'd7;   // 8 preamble cycles: 7 down to 0
   localparam logic [3:0]  GRD_LEN = 4'd1;   // 2 guard cycles: 1 down to 0

   localparam logic [1:0] MODE_CTRL = 2'd0;
   localparam logic [1:0] MODE_PRE  = 2'd1;
   localparam logic [1:0] MODE_GRD  = 2'd2;
   localparam logic [1:0] MODE_VID  = 2'd3;

   localparam logic [1:0] CTL_VIDEO_PRE = 2'b01;

   typedef enum logic [1:0] {ST_CTRL, ST_PRE, ST_GRD, ST_VID} state_t;

   typedef struct packed {
      logic       active;
      logic       vsync;
      logic       hsync;
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } sample_t;

   sample_t    pipe [DELAY];
   sample_t    in_sample;
   sample_t    dly;
   logic [3:0] run_cnt;
   logic       rising;
   logic       long_gap;
   logic       qualified;
   logic       too_short;
   state_t     state;
   logic [3:0] cnt;

   assign in_sample = {bus.active_in, bus.vsync_in, bus.hsync_in,
                       bus.red_in, bus.green_in, bus.blue_in};
   assign dly       = pipe[DELAY-1];

   // pipe[0] still holds the previous input sample, so it doubles as the edge history
   assign rising    = bus.active_in & ~pipe[0].active;
   assign long_gap  = (run_cnt >= RUN_MIN);
   assign qualified = rising & bus.hdmi_mode_in & long_gap;
   assign too_short = rising & bus.hdmi_mode_in & ~long_gap;

   always_ff @(posedge clk_pixel_in) begin
      if (!rst_n_in) begin
         run_cnt <= '0;
         // NOTE: the delay line is cleared on reset so no stale active sample
         // can reach the sequencer afterwards; this keeps it in plain flops.
         for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
      end else begin
         if (bus.active_in)
            run_cnt <= '0;
         else if (run_cnt != RUN_MIN)
            run_cnt <= run_cnt + 4'd1;
         pipe[0] <= in_sample;
         for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // The insertion window is exactly the 10 delayed samples still in the pipe
   // when the edge is seen, so PRE starts on the detecting edge itself.
   always_ff @(posedge clk_pixel_in) begin
      if (!rst_n_in) begin
         state             <= ST_CTRL;
         cnt               <= '0;
         bus.mode_out      <= MODE_CTRL;
         bus.c0_out        <= '0;
         bus.c1_out        <= '0;
         bus.c2_out        <= '0;
         bus.red_out       <= '0;
         bus.green_out     <= '0;
         bus.blue_out      <= '0;
         bus.violation_out <= 1'b0;
      end else begin
         bus.red_out       <= dly.red;
         bus.green_out     <= dly.green;
         bus.blue_out      <= dly.blue;
         bus.c0_out        <= {dly.vsync, dly.hsync};
         bus.c1_out        <= '0;
         bus.c2_out        <= '0;
         bus.violation_out <= too_short;

         unique case (state)
            ST_CTRL: begin
               if (qualified) begin
                  state        <= ST_PRE;
                  cnt          <= PRE_LEN;
                  bus.mode_out <= MODE_PRE;
                  bus.c1_out   <= CTL_VIDEO_PRE;
               end else if (dly.active) begin
                  state        <= ST_VID;
                  bus.mode_out <= MODE_VID;
               end else begin
                  bus.mode_out <= MODE_CTRL;
               end
            end
            ST_PRE: begin
               if (cnt == 4'd0) begin
                  state        <= ST_GRD;
                  cnt          <= GRD_LEN;
                  bus.mode_out <= MODE_GRD;
               end else begin
                  cnt          <= cnt - 4'd1;
                  bus.mode_out <= MODE_PRE;
                  bus.c1_out   <= CTL_VIDEO_PRE;
               end
            end
            ST_GRD: begin
               if (cnt == 4'd0) begin
                  state        <= dly.active ? ST_VID : ST_CTRL;
                  bus.mode_out <= dly.active ? MODE_VID : MODE_CTRL;
               end else begin
                  cnt          <= cnt - 4'd1;
                  bus.mode_out <= MODE_GRD;
               end
            end
            ST_VID: begin
               if (dly.active) begin
                  bus.mode_out <= MODE_VID;
               end else begin
                  state        <= ST_CTRL;
                  bus.mode_out <= MODE_CTRL;
               end
            end
            default: begin
               state        <= ST_CTRL;
               bus.mode_out <= MODE_CTRL;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Scoreboard bench for hdmi_period_sequencer: directed runs push expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_hdmi_period_sequencer;
   localparam logic [1:0] M_CTRL = 2'd0;
   localparam logic [1:0] M_PRE  = 2'd1;
   localparam logic [1:0] M_GRD  = 2'd2;
   localparam logic [1:0] M_VID  = 2'd3;

   typedef struct packed {
      logic       vs;
      logic       hs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   typedef struct packed {
      logic [1:0] mode;
      logic       viol;
      pix_t       pix;
   } exp_t;

   logic clk_pixel_in = 1'b0;
   logic rst_n_in     = 1'b0;

   hdmi_period_sequencer_if bus ();

   hdmi_period_sequencer dut (
      .clk_pixel_in (clk_pixel_in),
      .rst_n_in     (rst_n_in),
      .bus          (bus)
   );

   always #5 clk_pixel_in = ~clk_pixel_in;

   exp_t sb   [$];
   pix_t hist [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   always @(negedge clk_pixel_in) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("mode_out",      32'(bus.mode_out),      32'(e.mode));
         check("violation_out", 32'(bus.violation_out), 32'(e.viol));
         check("c1_out",        32'(bus.c1_out),        (e.mode == M_PRE) ? 32'd1 : 32'd0);
         check("c2_out",        32'(bus.c2_out),        32'd0);
         check("c0_out",        32'(bus.c0_out),        32'({e.pix.vs, e.pix.hs}));
         check("rgb_out",       32'({bus.red_out, bus.green_out, bus.blue_out}),
                                32'({e.pix.r, e.pix.g, e.pix.b}));
      end
   end

   // One clock of stimulus; sync toggles every cycle so c0 is checked in all modes.
   task automatic step(input logic rst, input logic act, input logic [7:0] red,
                       input logic hdmi, input logic [1:0] emode, input logic eviol);
      pix_t cur;
      exp_t e;
      cur.vs = cyc[2];
      cur.hs = cyc[0];
      cur.r  = red;
      cur.g  = ~red ^ cyc[7:0];
      cur.b  = cyc[7:0];
      rst_n_in         = ~rst;
      bus.active_in    = act;
      bus.hsync_in     = cur.hs;
      bus.vsync_in     = cur.vs;
      bus.red_in       = cur.r;
      bus.green_in     = cur.g;
      bus.blue_in      = cur.b;
      bus.hdmi_mode_in = hdmi;
      if (rst) begin
         e = '0;
         hist.delete();
         repeat (10) hist.push_back('0);
      end else begin
         e.mode = emode;
         e.viol = eviol;
         e.pix  = hist.pop_front();
         hist.push_back(cur);
      end
      sb.push_back(e);
      cyc++;
      @(posedge clk_pixel_in);
      #1;
   endtask

   // 20 idle, 16 active (red=A5), 20 idle; hdmi_mode switches at switch_at.
   task automatic full_run(input logic hdmi_early, input logic hdmi_late,
                           input int switch_at, input logic insert);
      step(1'b1, 1'b0, 8'h00, hdmi_early, M_CTRL, 1'b0);
      for (int i = 0; i < 56; i++) begin
         logic       a;
         logic [1:0] m;
         a = (i >= 20 && i < 36);
         if (insert && i >= 20 && i < 28)      m = M_PRE;
         else if (insert && i >= 28 && i < 30) m = M_GRD;
         else if (i >= 30 && i < 46)           m = M_VID;
         else                                  m = M_CTRL;
         step(1'b0, a, a ? 8'hA5 : 8'(i), (i < switch_at) ? hdmi_early : hdmi_late, m, 1'b0);
      end
   endtask

   // 20 idle, 16 active, 11-sample gap, 5 active, 15 idle.
   task automatic gap_run(input logic hdmi);
      step(1'b1, 1'b0, 8'h00, hdmi, M_CTRL, 1'b0);
      for (int i = 0; i < 67; i++) begin
         logic       a;
         logic [1:0] m;
         a = (i >= 20 && i < 36) || (i >= 47 && i < 52);
         if (hdmi && i >= 20 && i < 28)                 m = M_PRE;
         else if (hdmi && i >= 28 && i < 30)            m = M_GRD;
         else if ((i >= 30 && i < 46) || (i >= 57 && i < 62)) m = M_VID;
         else                                           m = M_CTRL;
         step(1'b0, a, a ? 8'h3C : 8'(i * 3), hdmi, m, hdmi && (i == 47));
      end
   endtask

   // Reset lands on the 5th PRE edge; a full sequence must follow 12 idle samples.
   task automatic reset_run();
      step(1'b1, 1'b0, 8'h00, 1'b1, M_CTRL, 1'b0);
      for (int i = 0; i < 60; i++) begin
         logic       a;
         logic [1:0] m;
         a = (i >= 20 && i < 24) || (i >= 37 && i < 45);
         if ((i >= 20 && i < 24) || (i >= 37 && i < 45)) m = M_PRE;
         else if (i >= 45 && i < 47)                     m = M_GRD;
         else if (i >= 47 && i < 55)                     m = M_VID;
         else                                            m = M_CTRL;
         step(i == 24, a, a ? 8'h5A : 8'(i + 7), 1'b1, m, 1'b0);
      end
   endtask

   initial begin
      bus.active_in    = 1'b0;
      bus.hsync_in     = 1'b0;
      bus.vsync_in     = 1'b0;
      bus.red_in       = '0;
      bus.green_in     = '0;
      bus.blue_in      = '0;
      bus.hdmi_mode_in = 1'b0;

      full_run(1'b1, 1'b1, 0, 1'b1);   // HDMI: PRE x8, GRD x2, VID x16
      gap_run(1'b1);                   // short gap: violation, no insertion
      full_run(1'b0, 1'b0, 0, 1'b0);   // DVI: no insertion
      gap_run(1'b0);                   // DVI short gap: no violation
      reset_run();
      full_run(1'b1, 1'b0, 28, 1'b1);  // mode drops during GRD: unchanged

      @(negedge clk_pixel_in);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
